// File: rtl/proc_pkg.sv
// Shared definitions for the memory-stage data responder: FSM encoding,
// default geometry and the width of the word-address slice of a byte address.
package proc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DEPTH   = 64;
    localparam int unsigned DEFAULT_LATENCY = 2;
    localparam int unsigned WORD_ADDR_W     = 30;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data responder: accepts one load/store at a time, answers after
// LATENCY edges (one edge for rejected requests) and holds the pipeline meanwhile.
module data_mem_responder
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_rw,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_stall
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_rw;
    logic                   r_err;
    logic [AW-1:0]          r_word;
    logic [31:0]            r_wdata;
    logic                   r_resp_valid;
    logic                   r_resp_err;

    logic [WORD_ADDR_W-1:0] w_req_word;
    logic                   w_bad;
    logic                   w_we;
    logic [31:0]            w_rdata;

    assign w_req_word = i_req_addr[31:2];
    assign w_bad      = (i_req_addr[1:0] != 2'b00) || (32'(w_req_word) >= DEPTH);
    assign w_we       = (r_state == StWait) && (r_cnt == 4'd0) && r_rw && !r_err;

    // Rejected requests pass through WAIT with a zero count so they answer one
    // edge after acceptance; the commit strobe is masked by r_err.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_rw         <= 1'b0;
            r_err        <= 1'b0;
            r_word       <= '0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_rw    <= i_req_rw;
                        r_word  <= i_req_addr[2 +: AW];
                        r_wdata <= i_req_wdata;
                        r_err   <= w_bad;
                        r_cnt   <= w_bad ? 4'd0 : 4'(LATENCY - 1);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (r_word),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign o_req_ready  = (r_state == StIdle);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = (r_resp_valid && !r_rw && !r_err) ? w_rdata : 32'd0;
    assign o_stall      = ((r_state == StIdle) && i_req_valid) || (r_state == StWait);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default build (LATENCY=2) plus a
// LATENCY=1 build sharing clock and reset.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_rw;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    logic        l1_valid, l1_rw;
    logic [31:0] l1_addr, l1_wdata;
    logic        l1_ready, l1_resp_valid, l1_resp_err, l1_stall;
    logic [31:0] l1_resp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_rw     (req_rw),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_stall      (stall)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (l1_valid),
        .i_req_rw     (l1_rw),
        .i_req_addr   (l1_addr),
        .i_req_wdata  (l1_wdata),
        .o_req_ready  (l1_ready),
        .o_resp_valid (l1_resp_valid),
        .o_resp_rdata (l1_resp_rdata),
        .o_resp_err   (l1_resp_err),
        .o_stall      (l1_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and report edges after the accepting edge until resp_valid.
    task automatic run_req(input bit sel, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output logic err);
        if (sel) begin
            l1_valid = 1'b1; l1_rw = rw; l1_addr = addr; l1_wdata = wd;
        end else begin
            req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        end
        tick();
        req_valid = 1'b0;
        l1_valid  = 1'b0;
        lat = 0;
        while (!(sel ? l1_resp_valid : resp_valid) && lat < 20) begin
            tick();
            lat++;
        end
        rd  = sel ? l1_resp_rdata : resp_rdata;
        err = sel ? l1_resp_err : resp_err;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        l1_valid = 1'b0; l1_rw = 1'b0; l1_addr = 32'd0; l1_wdata = 32'd0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
        end
        checks++;
        if (resp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata);
        end
        checks++;
        if (resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall_idle: got %b want 0", stall);
        end
        req_valid = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall_follows_valid: got %b want 1", stall);
        end
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic err;
        run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, err);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err); end
        run_req(1'b0, 1'b0, 32'h10, 32'd0, lat, rd, err);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_rdata: got %h want deadbeef", rd);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic err;
        run_req(1'b0, 1'b1, 32'h00, 32'hA5A5A5A5, lat, rd, err);
        run_req(1'b0, 1'b0, 32'h02, 32'd0, lat, rd, err);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL mis_latency: got %0d want 1", lat); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", err); end
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL mis_rdata: got %h want 0", rd); end
        run_req(1'b0, 1'b1, 32'h02, 32'hFFFFFFFF, lat, rd, err);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL mis_wr_err: got %b want 1", err); end
        run_req(1'b0, 1'b0, 32'h00, 32'd0, lat, rd, err);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL mis_storage: got %h want a5a5a5a5", rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic err;
        run_req(1'b0, 1'b1, 32'h100, 32'h11111111, lat, rd, err);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", err); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL oor_latency: got %0d want 1", lat); end
        run_req(1'b0, 1'b0, 32'h00, 32'd0, lat, rd, err);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL oor_storage: got %h want a5a5a5a5", rd);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL oor_rd_err: got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic err;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h30; req_wdata = 32'h0000AAAA;
        #1;
        checks++;
        if ({req_ready, stall} !== 2'b11) begin
            errors++; $display("FAIL b2b_idle ready/stall: got %b want 11", {req_ready, stall});
        end
        tick();
        req_addr = 32'h34; req_wdata = 32'h0000BBBB;
        checks++;
        if ({req_ready, stall} !== 2'b01) begin
            errors++; $display("FAIL b2b_wait ready/stall: got %b want 01", {req_ready, stall});
        end
        tick();
        checks++;
        if ({req_ready, stall, resp_valid} !== 3'b010) begin
            errors++; $display("FAIL b2b_wait2: got %b want 010", {req_ready, stall, resp_valid});
        end
        tick();
        checks++;
        if ({req_ready, stall, resp_valid} !== 3'b001) begin
            errors++; $display("FAIL b2b_resp: got %b want 001", {req_ready, stall, resp_valid});
        end
        tick();
        checks++;
        if ({req_ready, stall, resp_valid} !== 3'b110) begin
            errors++; $display("FAIL b2b_idle2: got %b want 110", {req_ready, stall, resp_valid});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept: got %b want 0", req_ready);
        end
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second_resp: got %b want 1", resp_valid);
        end
        tick();
        run_req(1'b0, 1'b0, 32'h30, 32'd0, lat, rd, err);
        checks++;
        if (rd !== 32'h0000AAAA) begin
            errors++; $display("FAIL b2b_rd30: got %h want 0000aaaa", rd);
        end
        run_req(1'b0, 1'b0, 32'h34, 32'd0, lat, rd, err);
        checks++;
        if (rd !== 32'h0000BBBB) begin
            errors++; $display("FAIL b2b_rd34: got %h want 0000bbbb", rd);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic err; bit seen;
        run_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, lat, rd, err);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            errors++; $display("FAIL abort_state: got %b want 10", {req_ready, resp_valid});
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_resp: got %b want 0", seen);
        end
        run_req(1'b0, 1'b0, 32'h20, 32'd0, lat, rd, err);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL abort_storage: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_latency1();
        int lat; logic [31:0] rd; logic err;
        run_req(1'b1, 1'b1, 32'h04, 32'h0BADF00D, lat, rd, err);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL l1_wr_latency: got %0d want 1", lat); end
        run_req(1'b1, 1'b0, 32'h04, 32'd0, lat, rd, err);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL l1_rd_latency: got %0d want 1", lat); end
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++; $display("FAIL l1_rd_rdata: got %h want 0badf00d", rd);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL l1_rd_err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2: clock edges from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  memory-stage request present.
REQ-006 req_rw  input  1  1 = write, 0 = read (same sense as memWriteM).
REQ-007 req_addr  input  32  byte address (ALUOutM).
REQ-008 req_wdata  input  32  store data (writeDataM).
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 resp_rdata  output  32  load data, valid when resp_valid is high.
REQ-012 resp_err  output  1  request rejected (misaligned or out of range), valid with resp_valid.
REQ-013 stall  output  1  pipeline hold request to the hazard logic.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready=1; on an edge with req_valid=1, capture rw/addr/wdata; goes to RESP with error if addr[1:0]!=0 or addr[31:2]>=DEPTH, else to WAIT with counter loaded LATENCY-1.
REQ-016 WAIT: counter decrements each edge; at an edge with counter==0, goes to RESP; for a write, mem[addr[31:2]] <= wdata on that same edge.
REQ-017 Accepted request at edge N SHALL produce resp_valid high for exactly the cycle following edge N+LATENCY (error path: following edge N+1).
REQ-018 RESP: resp_valid=1; resp_rdata = stored word for reads, 0 for writes and errors; resp_err=1 only on the error path; next edge returns to IDLE.
REQ-019 Error requests SHALL never modify storage.
REQ-020 req_ready=0 in WAIT and RESP; req_valid in those states is ignored, not queued.
REQ-021 stall = (IDLE and req_valid) or WAIT; stall SHALL be 0 in RESP so the pipeline advances with the response.
REQ-022 Maximum throughput: one request per LATENCY+2 edges.
REQ-023 Read after write to the same word SHALL return the written value.
REQ-024 Storage read is combinational from the captured address; write is synchronous.

Reset
REQ-025 rst asserted: state=IDLE, counter=0, captured registers=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after release, stall follows req_valid.
REQ-026 rst mid-operation SHALL abort the request; a write whose commit edge has not occurred SHALL not be performed.
REQ-027 Storage contents SHALL not be cleared by rst; contents are undefined at power-up.

Structure
REQ-028 Shared package proc_pkg holds the FSM state encoding, default DEPTH and LATENCY, and the word-address slice width.
REQ-029 One sub-module dmem_array (DEPTH x 32, sync write, async read) holds storage; FSM, counter and error check live in data_mem_responder.

Verification
REQ-030 Write 0xDEADBEEF to 0x10, then read 0x10 -> write resp_valid after 2 edges with rdata 0; read resp_valid after 2 edges, rdata 0xDEADBEEF, resp_err 0.
REQ-031 Read 0x02 (misaligned) -> resp_valid after 1 edge, resp_err 1, rdata 0; storage unchanged.
REQ-032 Write 0x100 (word 64, DEPTH=64) -> resp_err 1; subsequent read of 0x00 returns its prior value.
REQ-033 req_valid held high continuously across two writes -> second accepted only at the first IDLE after RESP; stall high in IDLE-with-request and WAIT, low in RESP.
REQ-034 Write 0x12345678 to 0x20, assert rst one edge after acceptance -> no resp_valid; subsequent read of 0x20 returns the pre-write value.
REQ-035 LATENCY=1 build: read 0x04 -> resp_valid in the cycle after edge N+1.
